// File: rtl/onehot_strobe_decoder.sv
// Binary code -> one-hot/thermometer strobe, each strobe held HOLD cycles; 1-cycle accept-to-strobe latency.
// in_ready drops only while the 1-entry buffer is full or flush is high; codes are never dropped.
module onehot_strobe_decoder #(
    parameter int IN_W   = 3,
    parameter int OUT_W  = 2**IN_W,
    parameter int HOLD   = 2,
    parameter int THERMO = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_code,
    output logic [OUT_W-1:0] out,
    output logic             out_valid,
    output logic             busy
);

    typedef enum logic [0:0] {ST_IDLE, ST_HOLD} state_t;

    localparam logic [7:0] CNT_RELOAD = 8'(HOLD - 1);

    state_t           state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [OUT_W-1:0] out_q, out_d;
    logic             out_valid_q, out_valid_d;
    logic [IN_W-1:0]  buf_q, buf_d;
    logic             buf_full_q, buf_full_d;
    logic             accept;

    // Thermometer form is (2<<c)-1 computed one bit wider so code OUT_W-1 yields all ones.
    function automatic logic [OUT_W-1:0] decode(input logic [IN_W-1:0] c);
        logic [OUT_W:0] w;
        if (THERMO != 0) begin
            w = ((OUT_W+1)'(2) << c) - (OUT_W+1)'(1);
        end else begin
            w = (OUT_W+1)'(1) << c;
        end
        return w[OUT_W-1:0];
    endfunction

    assign in_ready  = !buf_full_q && !flush;
    assign accept    = in_valid && in_ready;
    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign busy      = (state_q == ST_HOLD) || buf_full_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        buf_d       = buf_q;
        buf_full_d  = buf_full_q;
        if (flush) begin
            state_d     = ST_IDLE;
            cnt_d       = '0;
            out_d       = '0;
            out_valid_d = 1'b0;
            buf_full_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        out_d       = decode(in_code);
                        out_valid_d = 1'b1;
                        cnt_d       = CNT_RELOAD;
                        state_d     = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (cnt_q != 8'd0) begin
                        cnt_d = cnt_q - 8'd1;
                        if (accept) begin
                            buf_d      = in_code;
                            buf_full_d = 1'b1;
                        end
                    end else if (buf_full_q) begin
                        out_d      = decode(buf_q);
                        cnt_d      = CNT_RELOAD;
                        buf_full_d = 1'b0;
                    end else if (accept) begin
                        // Bypass keeps back-to-back strobes gap-free when the buffer is empty.
                        out_d = decode(in_code);
                        cnt_d = CNT_RELOAD;
                    end else begin
                        out_d       = '0;
                        out_valid_d = 1'b0;
                        state_d     = ST_IDLE;
                    end
                end
                default: begin
                    state_d     = ST_IDLE;
                    out_d       = '0;
                    out_valid_d = 1'b0;
                    buf_full_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            buf_q       <= '0;
            buf_full_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            buf_q       <= buf_d;
            buf_full_q  <= buf_full_d;
        end
    end

endmodule

// File: tb/tb_onehot_strobe_decoder.sv
// Directed bench: one-hot HOLD=2, thermometer HOLD=2 and one-hot HOLD=3 instances share clock and reset.
module tb_onehot_strobe_decoder;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    int ncmp = 0;
    int nfail = 0;

    // a: one-hot HOLD=2, t: thermometer HOLD=2, h: one-hot HOLD=3
    logic       a_flush = 1'b0, a_valid = 1'b0, a_ready, a_ovld, a_busy;
    logic [2:0] a_code = '0;
    logic [7:0] a_out;
    logic       t_flush = 1'b0, t_valid = 1'b0, t_ready, t_ovld, t_busy;
    logic [2:0] t_code = '0;
    logic [7:0] t_out;
    logic       h_flush = 1'b0, h_valid = 1'b0, h_ready, h_ovld, h_busy;
    logic [2:0] h_code = '0;
    logic [7:0] h_out;

    onehot_strobe_decoder #(.IN_W(3), .OUT_W(8), .HOLD(2), .THERMO(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .flush(a_flush), .in_valid(a_valid), .in_ready(a_ready),
        .in_code(a_code), .out(a_out), .out_valid(a_ovld), .busy(a_busy));
    onehot_strobe_decoder #(.IN_W(3), .OUT_W(8), .HOLD(2), .THERMO(1)) dut_t (
        .clk(clk), .rst_n(rst_n), .flush(t_flush), .in_valid(t_valid), .in_ready(t_ready),
        .in_code(t_code), .out(t_out), .out_valid(t_ovld), .busy(t_busy));
    onehot_strobe_decoder #(.IN_W(3), .OUT_W(8), .HOLD(3), .THERMO(0)) dut_h (
        .clk(clk), .rst_n(rst_n), .flush(h_flush), .in_valid(h_valid), .in_ready(h_ready),
        .in_code(h_code), .out(h_out), .out_valid(h_ovld), .busy(h_busy));

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] prio_enc(input logic [7:0] v);
        logic [7:0] r;
        r = 8'hFF;
        for (int i = 7; i >= 0; i--) begin
            if (v[i] && r == 8'hFF) r = 8'(i);
        end
        return r;
    endfunction

    initial begin
        logic [7:0] exp_t [3];
        logic [2:0] tcodes [3];
        int  k;
        logic prev_acc;
        exp_t[0] = 8'h01; exp_t[1] = 8'h0F; exp_t[2] = 8'hFF;
        tcodes[0] = 3'd0; tcodes[1] = 3'd3; tcodes[2] = 3'd7;

        // 1. async reset with no clock edge yet
        #1 rst_n = 1'b0;
        #1;
        chk("rst_out", a_out, 8'h00);
        chk("rst_ovld", {7'd0, a_ovld}, 8'd0);
        chk("rst_h_out", h_out, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_ready", {7'd0, a_ready}, 8'd1);
        chk("rel_busy", {7'd0, a_busy}, 8'd0);

        // 2. single code 5, HOLD=2
        @(negedge clk);
        a_valid = 1'b1; a_code = 3'd5;
        @(negedge clk);
        a_valid = 1'b0;
        chk("t2_T1_out", a_out, 8'b0010_0000);
        chk("t2_T1_ovld", {7'd0, a_ovld}, 8'd1);
        @(negedge clk);
        chk("t2_T2_out", a_out, 8'b0010_0000);
        @(negedge clk);
        chk("t2_T3_out", a_out, 8'h00);
        chk("t2_T3_ovld", {7'd0, a_ovld}, 8'd0);

        // 3. streaming codes 0..7 with in_valid held
        k = 0;
        a_valid = 1'b1; a_code = 3'd0;
        #1;
        prev_acc = a_valid & a_ready;
        for (int n = 1; n <= 17; n++) begin
            @(negedge clk);
            if (n <= 16) begin
                chk("t3_out", a_out, 8'h01 << ((n - 1) / 2));
                chk("t3_ovld", {7'd0, a_ovld}, 8'd1);
            end else begin
                chk("t3_idle_out", a_out, 8'h00);
                chk("t3_idle_ovld", {7'd0, a_ovld}, 8'd0);
            end
            if (prev_acc) k++;
            if (k > 7) a_valid = 1'b0;
            else a_code = 3'(k);
            #1;
            if (n <= 14) chk("t3_ready", {7'd0, a_ready}, ((n % 2) == 1) ? 8'd1 : 8'd0);
            prev_acc = a_valid & a_ready;
        end

        // 4. thermometer codes 0,3,7
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            t_valid = 1'b1; t_code = tcodes[i];
            @(negedge clk);
            t_valid = 1'b0;
            chk("t4_out", t_out, exp_t[i]);
            chk("t4_reenc", prio_enc(t_out), 8'(tcodes[i]));
            @(negedge clk);
            chk("t4_hold", t_out, exp_t[i]);
            @(negedge clk);
            chk("t4_idle", {7'd0, t_ovld}, 8'd0);
        end

        // 5. HOLD=3, buffer full, flush mid-hold
        @(negedge clk);
        h_valid = 1'b1; h_code = 3'd2;
        @(negedge clk);
        chk("t5_out", h_out, 8'h04);
        h_code = 3'd6;
        @(negedge clk);
        h_valid = 1'b0;
        chk("t5_mid_out", h_out, 8'h04);
        chk("t5_buf_ready", {7'd0, h_ready}, 8'd0);
        chk("t5_buf_busy", {7'd0, h_busy}, 8'd1);
        h_flush = 1'b1;
        @(negedge clk);
        h_flush = 1'b0;
        #1;
        chk("t5_fl_out", h_out, 8'h00);
        chk("t5_fl_ovld", {7'd0, h_ovld}, 8'd0);
        chk("t5_fl_ready", {7'd0, h_ready}, 8'd1);
        chk("t5_fl_busy", {7'd0, h_busy}, 8'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t5_no_buf", h_out, 8'h00);
        end

        // 6. async reset pulse mid-hold
        @(negedge clk);
        a_valid = 1'b1; a_code = 3'd3;
        @(negedge clk);
        a_valid = 1'b0;
        chk("t6_pre_out", a_out, 8'h08);
        #1 rst_n = 1'b0;
        #1;
        chk("t6_rst_out", a_out, 8'h00);
        chk("t6_rst_ovld", {7'd0, a_ovld}, 8'd0);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("t6_rel_ready", {7'd0, a_ready}, 8'd1);
        chk("t6_rel_out", a_out, 8'h00);
        a_valid = 1'b1; a_code = 3'd1;
        @(negedge clk);
        a_valid = 1'b0;
        chk("t6_post_out", a_out, 8'h02);
        chk("t6_post_ovld", {7'd0, a_ovld}, 8'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
